rd_burst_ctrl: RTL and testbench
================================

# rd_burst_ctrl

Read-burst engine between the frame read buffer and the DDR controller's AXI4 read port, entirely in the `ddr_clk` domain. It accepts one line request at a time (start address plus beat count), splits it into AXI bursts of at most `MAX_BURST` beats, and forwards the returned beats as `ddr_rdata`/`ddr_rdata_en`. When the last beat is delivered it pulses `ddr_rdone`.

## Interface
Parameters:
- `ADDR_WIDTH`, 27: DDR word-address width. Unit is one `8*DQ_WIDTH`-bit beat.
- `LEN_WIDTH`, 16: request length width, in beats.
- `DQ_WIDTH`, 16: DDR DQ width. Data bus is `8*DQ_WIDTH` = 128 bits.
- `MAX_BURST`, 16: maximum beats per AR. Legal range is 1..256.

Ports:
- `ddr_clk`, in, 1: sole clock.
- `ddr_rstn`, in, 1: reset, synchronous, active-low.
- `ddr_rreq`, in, 1: one-cycle request strobe.
- `ddr_raddr`, in, `ADDR_WIDTH`: first beat address, sampled with `ddr_rreq`.
- `ddr_rd_len`, in, `LEN_WIDTH`: beat count, sampled with `ddr_rreq`.
- `ddr_rrdy`, out, 1: high when IDLE (a request will be accepted).
- `ddr_rdone`, out, 1: one-cycle pulse, request complete.
- `ddr_rdata`, out, `8*DQ_WIDTH`: beat data.
- `ddr_rdata_en`, out, 1: beat valid.
- `axi_araddr`, out, `ADDR_WIDTH`: burst start word address.
- `axi_arlen`, out, 8: beats−1.
- `axi_arvalid`, out, 1.
- `axi_arready`, in, 1.
- `axi_rdata`, in, `8*DQ_WIDTH`.
- `axi_rvalid`, in, 1.
- `axi_rlast`, in, 1.
- `axi_rready`, out, 1.
- `err_rlast`, out, 1: sticky; `axi_rlast` disagreed with the internal beat count.

## Operation
- States: IDLE, ADDR, DATA, DONE.
- **IDLE.** `ddr_rrdy`=1. On `ddr_rreq`, latch `cur_addr`=`ddr_raddr` and `remain`=`ddr_rd_len`.
  - `ddr_rd_len`≠0 → ADDR.
  - `ddr_rd_len`=0 → DONE.
- **ADDR.** `axi_arvalid`=1, with `axi_araddr`=`cur_addr` and `axi_arlen`=min(`remain`,`MAX_BURST`)−1.
  - Address and length are held stable until `axi_arready`.
  - On handshake, load `beat_cnt` = burst length → DATA.
- **DATA.** `axi_rready`=1.
  - Each `axi_rvalid` beat decrements `beat_cnt` and `remain`, and forwards the beat.
  - When `beat_cnt` reaches 0: `cur_addr` += burst length (modulo 2^`ADDR_WIDTH`, no boundary splitting), then `remain`≠0 → ADDR, else → DONE.
- **DONE.** `ddr_rdone`=1 for exactly one cycle → IDLE.
- Only one AR is outstanding at a time.
- Beat count governs burst end. `axi_rlast` is only checked:
  - `rlast`=1 on a non-final beat, or `rlast`=0 on the final beat, sets `err_rlast`.
  - `err_rlast` clears only on reset.
- `ddr_rreq` outside IDLE is ignored, with no state change.
- Reset mid-operation: the FSM returns to IDLE at once and all counters clear. The DDR controller shares `ddr_rstn`, so an abandoned AR/R is acceptable.

## Timing
- Reset values:
  - `ddr_rrdy`=1 (IDLE).
  - 0 on `ddr_rdone`, `ddr_rdata_en`, `axi_arvalid`, `axi_rready` and `err_rlast`.
  - 0 on `axi_araddr`, `axi_arlen` and `ddr_rdata`.
- `ddr_rreq` at cycle T:
  - `ddr_rrdy`=0 and `axi_arvalid`=1 from T+1.
  - For a zero-length request, `ddr_rdone` fires at T+1.
- Data path is registered:
  - `ddr_rdata_en`/`ddr_rdata` appear one cycle after the `axi_rvalid`&`axi_rready` beat.
  - Gaps in `rvalid` pass through unchanged.
- Completion:
  - `ddr_rdone` pulses the cycle after the final `ddr_rdata_en`.
  - `ddr_rrdy` returns 1 the cycle after `ddr_rdone`.
- Between bursts, the next `axi_arvalid` rises the cycle after the last beat of the previous burst is accepted.
- `axi_rready` is 0 outside DATA.

## Structure
- Shared package `rd_burst_pkg`: state encoding (IDLE/ADDR/DATA/DONE), `ARLEN_W`=8.
- Burst length = min(`remain`,`MAX_BURST`), computed with `LEN_WIDTH`-bit compare. The `axi_arlen` subtract is truncated to 8 bits.
- No sub-module; single flat module of roughly 150–250 lines.

## Test plan
- **Full line, ideal slave.** len=160, addr=0x1000, `MAX_BURST`=16 → 10 ARs at 0x1000, 0x1010…0x1090, each `arlen`=15; 160 `ddr_rdata_en` in order; one `ddr_rdone`; `err_rlast`=0.
- **Short tail.** len=20, addr=0 → ARs (0, `arlen` 15) then (16, `arlen` 3); 20 beats; one `rdone`.
- **Zero length.** len=0 → no `arvalid`; `rdone` at T+1; `rrdy` high at T+2.
- **Backpressure.** `arready` low for 5 cycles → `arvalid`/`araddr`/`arlen` stable throughout; random `rvalid` gaps → beat count and data order intact.
- **Protocol errors.** `rlast` asserted on beat 8 of 16 → `err_rlast`=1 and stays set; transfer still completes with 16 beats. A second `ddr_rreq` mid-transfer is ignored.
- **Reset mid-burst.** `ddr_rstn`=0 during DATA → next cycle IDLE, `rrdy`=1, all outputs at reset values; a fresh len=16 request then completes normally.

Source files
------------

// File: rtl/rd_burst_pkg.sv
// Shared definitions for the DDR read-burst engine: FSM state encoding and
// AXI length field width.
package rd_burst_pkg;

  localparam int ARLEN_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/rd_burst_ctrl.sv
// Read-burst engine: splits one line request into AXI4 read bursts of at most
// MAX_BURST beats and forwards the returned beats, pulsing ddr_rdone at the end.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | ddr_rrdy high, waiting for ddr_rreq
// ST_ADDR | axi_arvalid high, address/length held until axi_arready
// ST_DATA | axi_rready high while beats of the current burst remain
// ST_DONE | final beat forwarded, ddr_rdone high for one cycle
module rd_burst_ctrl
  import rd_burst_pkg::*;
#(
  parameter int ADDR_WIDTH = 27,
  parameter int LEN_WIDTH  = 16,
  parameter int DQ_WIDTH   = 16,
  parameter int MAX_BURST  = 16
) (
  input  logic                    ddr_clk,
  input  logic                    ddr_rstn,
  input  logic                    ddr_rreq,
  input  logic [ADDR_WIDTH-1:0]   ddr_raddr,
  input  logic [LEN_WIDTH-1:0]    ddr_rd_len,
  output logic                    ddr_rrdy,
  output logic                    ddr_rdone,
  output logic [8*DQ_WIDTH-1:0]   ddr_rdata,
  output logic                    ddr_rdata_en,
  output logic [ADDR_WIDTH-1:0]   axi_araddr,
  output logic [ARLEN_W-1:0]      axi_arlen,
  output logic                    axi_arvalid,
  input  logic                    axi_arready,
  input  logic [8*DQ_WIDTH-1:0]   axi_rdata,
  input  logic                    axi_rvalid,
  input  logic                    axi_rlast,
  output logic                    axi_rready,
  output logic                    err_rlast
);

  localparam int BCNT_W = $clog2(MAX_BURST + 1);
  localparam logic [LEN_WIDTH-1:0] MAXB = LEN_WIDTH'(MAX_BURST);

  state_t                  r_state;
  logic [ADDR_WIDTH-1:0]   r_cur_addr;
  logic [LEN_WIDTH-1:0]    r_remain;
  logic [LEN_WIDTH-1:0]    r_blen;
  logic [BCNT_W-1:0]       r_beat_cnt;
  logic                    r_rrdy;
  logic                    r_rdone;
  logic [8*DQ_WIDTH-1:0]   r_rdata;
  logic                    r_rdata_en;
  logic [ARLEN_W-1:0]      r_arlen;
  logic                    r_arvalid;
  logic                    r_rready;
  logic                    r_err_rlast;

  logic                    w_beat;
  logic                    w_last_beat;
  logic [LEN_WIDTH-1:0]    w_remain_dec;
  logic [LEN_WIDTH-1:0]    w_req_blen;
  logic [LEN_WIDTH-1:0]    w_next_blen;
  logic [ADDR_WIDTH-1:0]   w_next_addr;

  assign w_beat       = axi_rvalid & r_rready;
  assign w_last_beat  = (r_beat_cnt == BCNT_W'(1));
  assign w_remain_dec = r_remain - LEN_WIDTH'(1);
  assign w_req_blen   = (ddr_rd_len < MAXB) ? ddr_rd_len : MAXB;
  assign w_next_blen  = (w_remain_dec < MAXB) ? w_remain_dec : MAXB;
  // Plain modulo wrap; bursts are never split at any address boundary.
  assign w_next_addr  = r_cur_addr + ADDR_WIDTH'(r_blen);

  always_ff @(posedge ddr_clk) begin
    if (!ddr_rstn) begin
      r_state     <= ST_IDLE;
      r_cur_addr  <= '0;
      r_remain    <= '0;
      r_blen      <= '0;
      r_beat_cnt  <= '0;
      r_rrdy      <= 1'b1;
      r_rdone     <= 1'b0;
      r_rdata     <= '0;
      r_rdata_en  <= 1'b0;
      r_arlen     <= '0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_err_rlast <= 1'b0;
    end else begin
      r_rdata_en <= w_beat;
      if (w_beat) begin
        r_rdata <= axi_rdata;
        if (axi_rlast != w_last_beat) r_err_rlast <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (ddr_rreq) begin
            r_cur_addr <= ddr_raddr;
            r_remain   <= ddr_rd_len;
            r_rrdy     <= 1'b0;
            if (ddr_rd_len != '0) begin
              r_state   <= ST_ADDR;
              r_arvalid <= 1'b1;
              r_blen    <= w_req_blen;
              r_arlen   <= ARLEN_W'(w_req_blen - LEN_WIDTH'(1));
            end else begin
              r_state <= ST_DONE;
              r_rdone <= 1'b1;
            end
          end
        end
        ST_ADDR: begin
          if (axi_arready) begin
            r_arvalid  <= 1'b0;
            r_rready   <= 1'b1;
            r_beat_cnt <= BCNT_W'(r_blen);
            r_state    <= ST_DATA;
          end
        end
        ST_DATA: begin
          // beat_cnt==0 here is the one-cycle wait for the last registered beat.
          if (r_beat_cnt == '0) begin
            r_state <= ST_DONE;
            r_rdone <= 1'b1;
          end else if (w_beat) begin
            r_beat_cnt <= r_beat_cnt - BCNT_W'(1);
            r_remain   <= w_remain_dec;
            if (w_last_beat) begin
              r_cur_addr <= w_next_addr;
              r_rready   <= 1'b0;
              if (w_remain_dec != '0) begin
                r_state   <= ST_ADDR;
                r_arvalid <= 1'b1;
                r_blen    <= w_next_blen;
                r_arlen   <= ARLEN_W'(w_next_blen - LEN_WIDTH'(1));
              end
            end
          end
        end
        ST_DONE: begin
          r_rdone <= 1'b0;
          r_rrdy  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ddr_rrdy     = r_rrdy;
  assign ddr_rdone    = r_rdone;
  assign ddr_rdata    = r_rdata;
  assign ddr_rdata_en = r_rdata_en;
  assign axi_araddr   = r_cur_addr;
  assign axi_arlen    = r_arlen;
  assign axi_arvalid  = r_arvalid;
  assign axi_rready   = r_rready;
  assign err_rlast    = r_err_rlast;

endmodule

// File: tb/tb_rd_burst_ctrl.sv
// Scoreboard bench for rd_burst_ctrl: a request-level model fills expected
// AR/beat/done queues, a behavioural AXI slave answers, a monitor compares.
module tb_rd_burst_ctrl;

  typedef struct {
    logic [26:0] addr;
    logic [7:0]  len;
  } ar_t;

  logic         ddr_clk = 1'b0;
  logic         ddr_rstn;
  logic         ddr_rreq;
  logic [26:0]  ddr_raddr;
  logic [15:0]  ddr_rd_len;
  logic         ddr_rrdy;
  logic         ddr_rdone;
  logic [127:0] ddr_rdata;
  logic         ddr_rdata_en;
  logic [26:0]  axi_araddr;
  logic [7:0]   axi_arlen;
  logic         axi_arvalid;
  logic         axi_arready;
  logic [127:0] axi_rdata;
  logic         axi_rvalid;
  logic         axi_rlast;
  logic         axi_rready;
  logic         err_rlast;

  rd_burst_ctrl dut (
    .ddr_clk(ddr_clk), .ddr_rstn(ddr_rstn), .ddr_rreq(ddr_rreq),
    .ddr_raddr(ddr_raddr), .ddr_rd_len(ddr_rd_len), .ddr_rrdy(ddr_rrdy),
    .ddr_rdone(ddr_rdone), .ddr_rdata(ddr_rdata), .ddr_rdata_en(ddr_rdata_en),
    .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arvalid(axi_arvalid),
    .axi_arready(axi_arready), .axi_rdata(axi_rdata), .axi_rvalid(axi_rvalid),
    .axi_rlast(axi_rlast), .axi_rready(axi_rready), .err_rlast(err_rlast)
  );

  always #5 ddr_clk = ~ddr_clk;

  int           n_vec = 0;
  int           n_err = 0;
  logic [127:0] exp_data[$];
  ar_t          exp_ar[$];
  bit           exp_done[$];
  bit           mon_en = 1'b1;
  bit           err_exp = 1'b0;
  bit           ar_rand = 1'b0;
  bit           r_gaps = 1'b0;
  int           ar_hold = 0;
  int           inj_pos = -1;

  function automatic logic [127:0] beat_data(input logic [26:0] a);
    logic [31:0] w;
    w = {5'b0, a};
    return {w, ~w, w * 32'h9E3779B9, 32'hC0DE0000 ^ w};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Request-level model: beats are consecutive words, ARs are chunks of <=16.
  task automatic push_req(input logic [26:0] a, input int len);
    logic [26:0] ca;
    int rem, b;
    for (int i = 0; i < len; i++) exp_data.push_back(beat_data(a + 27'(i)));
    ca = a;
    rem = len;
    while (rem > 0) begin
      b = (rem < 16) ? rem : 16;
      exp_ar.push_back('{ca, 8'(b - 1)});
      ca = ca + 27'(b);
      rem -= b;
    end
    exp_done.push_back(len == 0);
  endtask

  task automatic issue(input logic [26:0] a, input int len, input bit accepted);
    @(posedge ddr_clk); #1;
    ddr_rreq = 1'b1;
    ddr_raddr = a;
    ddr_rd_len = 16'(len);
    if (accepted) push_req(a, len);
    @(posedge ddr_clk); #1;
    ddr_rreq = 1'b0;
  endtask

  task automatic wait_done(input int max);
    int n;
    n = 0;
    while ((exp_done.size() != 0 || !ddr_rrdy) && n < max) begin
      @(negedge ddr_clk);
      n++;
    end
    if (exp_done.size() != 0 || !ddr_rrdy) begin
      check("timeout", 0, 1);
      exp_data.delete();
      exp_ar.delete();
      exp_done.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rrdy"}, ddr_rrdy, 1);
    check({tag, "_rdone"}, ddr_rdone, 0);
    check({tag, "_rdata_en"}, ddr_rdata_en, 0);
    check({tag, "_arvalid"}, axi_arvalid, 0);
    check({tag, "_rready"}, axi_rready, 0);
    check({tag, "_err_rlast"}, err_rlast, 0);
    check({tag, "_araddr"}, axi_araddr, 0);
    check({tag, "_arlen"}, axi_arlen, 0);
    check({tag, "_rdata"}, ddr_rdata, 0);
  endtask

  // AXI slave: drives on negedge+1, so DUT and slave values are stable at negedge.
  initial begin
    bit          s_busy;
    logic [26:0] s_addr;
    int          s_len, s_pos;
    logic        sp_arvalid, sp_rready;
    logic [26:0] sp_araddr;
    logic [7:0]  sp_arlen;
    s_busy = 0; s_addr = '0; s_len = 0; s_pos = 0;
    sp_arvalid = 0; sp_rready = 0; sp_araddr = '0; sp_arlen = '0;
    axi_arready = 0; axi_rvalid = 0; axi_rlast = 0; axi_rdata = '0;
    forever begin
      @(negedge ddr_clk); #1;
      if (!ddr_rstn) begin
        s_busy = 0; sp_arvalid = 0; sp_rready = 0;
        axi_arready = 0; axi_rvalid = 0; axi_rlast = 0;
        continue;
      end
      if (s_busy && sp_rready && axi_rvalid) begin
        s_pos++;
        if (s_pos == s_len) s_busy = 0;
      end
      if (sp_arvalid && axi_arready) begin
        s_busy = 1;
        s_addr = sp_araddr;
        s_len = int'(sp_arlen) + 1;
        s_pos = 0;
      end
      if (axi_arvalid && ar_hold > 0) begin
        axi_arready = 1'b0;
        ar_hold--;
      end else begin
        axi_arready = ar_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (s_busy && (!r_gaps || $urandom_range(0, 2) != 0)) begin
        axi_rvalid = 1'b1;
        axi_rdata = beat_data(s_addr + 27'(s_pos));
        axi_rlast = (s_pos == s_len - 1) ^ (s_pos == inj_pos);
      end else begin
        axi_rvalid = 1'b0;
        axi_rlast = 1'b0;
      end
      sp_arvalid = axi_arvalid;
      sp_araddr = axi_araddr;
      sp_arlen = axi_arlen;
      sp_rready = axi_rready;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents an AR, a beat or rdone.
  initial begin
    logic        p_arvalid, p_rready, p_rdata_en;
    logic [26:0] p_araddr;
    logic [7:0]  p_arlen;
    int          m_left;
    ar_t         e;
    bit          zero;
    p_arvalid = 0; p_rready = 0; p_rdata_en = 0; p_araddr = '0; p_arlen = '0;
    m_left = 0;
    forever begin
      @(negedge ddr_clk);
      if (!ddr_rstn) begin
        p_arvalid = 0; p_rready = 0; p_rdata_en = 0; m_left = 0;
        continue;
      end
      if (mon_en) begin
        if (p_arvalid && axi_arready) begin
          if (exp_ar.size() == 0) check("ar_unexpected", 1, 0);
          else begin
            e = exp_ar.pop_front();
            check("araddr", p_araddr, e.addr);
            check("arlen", p_arlen, e.len);
          end
          m_left = int'(p_arlen) + 1;
        end else if (p_arvalid) begin
          check("ar_stable", {axi_arvalid, axi_araddr, axi_arlen}, {1'b1, p_araddr, p_arlen});
        end
        if (p_rready && axi_rvalid) begin
          m_left--;
          if (m_left == 0) check("ar_next", axi_arvalid, exp_ar.size() != 0);
        end
        if (axi_arvalid && exp_ar.size() == 0) check("ar_spurious", 1, 0);
        if (ddr_rdata_en) begin
          if (exp_data.size() == 0) check("beat_extra", 1, 0);
          else check("rdata", ddr_rdata, exp_data.pop_front());
        end
        if (ddr_rdone) begin
          if (exp_done.size() == 0) check("rdone_extra", 1, 0);
          else begin
            zero = exp_done.pop_front();
            check("rdone_beats_left", exp_data.size(), 0);
            if (!zero) check("rdone_after_last_beat", p_rdata_en, 1);
            check("err_rlast", err_rlast, err_exp);
          end
        end
      end
      p_arvalid = axi_arvalid;
      p_araddr = axi_araddr;
      p_arlen = axi_arlen;
      p_rready = axi_rready;
      p_rdata_en = ddr_rdata_en;
    end
  end

  initial begin
    logic [26:0] a;
    int          l, n;
    ddr_rstn = 1'b0;
    ddr_rreq = 1'b0;
    ddr_raddr = '0;
    ddr_rd_len = '0;
    repeat (3) @(posedge ddr_clk);
    @(negedge ddr_clk);
    check_reset_outputs("reset");
    @(posedge ddr_clk); #1;
    ddr_rstn = 1'b1;

    // Full line with ideal slave, plus request-to-AR latency.
    wait_done(50);
    issue(27'h1000, 160, 1);
    @(negedge ddr_clk);
    check("req_rrdy_low", ddr_rrdy, 0);
    check("req_arvalid_high", axi_arvalid, 1);
    wait_done(2000);

    // Short tail.
    issue(27'h0, 20, 1);
    wait_done(500);

    // Zero length: rdone at T+1, rrdy back at T+2, no AR.
    issue(27'h123, 0, 1);
    @(negedge ddr_clk);
    check("zero_rdone", ddr_rdone, 1);
    check("zero_rrdy", ddr_rrdy, 0);
    check("zero_arvalid", axi_arvalid, 0);
    @(negedge ddr_clk);
    check("zero_rdone_clear", ddr_rdone, 0);
    check("zero_rrdy_back", ddr_rrdy, 1);

    // Backpressure on AR and gaps on R.
    r_gaps = 1'b1;
    ar_hold = 5;
    issue(27'h2345, 40, 1);
    wait_done(2000);

    // Random requests, including address wrap at the top of the space.
    ar_rand = 1'b1;
    for (int i = 0; i < 20; i++) begin
      l = $urandom_range(0, 70);
      if ($urandom_range(0, 3) == 0) a = 27'h7FFFFF0 + 27'($urandom_range(0, 15));
      else a = 27'($urandom);
      issue(a, l, 1);
      wait_done(3000);
    end

    // rlast on beat 8 of 16, and a second request mid-transfer that must be ignored.
    ar_rand = 1'b0;
    r_gaps = 1'b0;
    inj_pos = 7;
    err_exp = 1'b1;
    issue(27'h4000, 16, 1);
    repeat (4) @(negedge ddr_clk);
    check("busy_rrdy", ddr_rrdy, 0);
    issue(27'h5555, 8, 0);
    wait_done(500);
    inj_pos = -1;
    issue(27'h6000, 16, 1);
    wait_done(500);
    check("err_sticky", err_rlast, 1);

    // Reset during DATA, then a normal request.
    mon_en = 1'b0;
    r_gaps = 1'b1;
    issue(27'h7000, 64, 1);
    n = 0;
    while (n < 5) begin
      @(negedge ddr_clk);
      if (ddr_rdata_en) n++;
    end
    check("pre_reset_rready", axi_rready | axi_arvalid, 1);
    @(posedge ddr_clk); #1;
    ddr_rstn = 1'b0;
    @(posedge ddr_clk);
    @(negedge ddr_clk);
    check_reset_outputs("midreset");
    @(posedge ddr_clk); #1;
    ddr_rstn = 1'b1;
    exp_data.delete();
    exp_ar.delete();
    exp_done.delete();
    err_exp = 1'b0;
    r_gaps = 1'b0;
    @(negedge ddr_clk);
    mon_en = 1'b1;
    issue(27'h8000, 16, 1);
    wait_done(500);

    check("end_beats_left", exp_data.size(), 0);
    check("end_ars_left", exp_ar.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
